adc_lane_formatter: RTL
=======================

# adc_lane_formatter

Parametrised ADC sample formatter that sits between the deserialiser output and `adc_to_datamover` on the ADC divided-clock domain. It converts each lane from the ADC's offset-binary code to two's complement, with per-lane P/N swap correction. It then reorders lanes so that 1/2/4/…-channel interleaved data leaves as sample-ordered words. It adds synchronised runtime mode control, a beat-drop window after mode changes, and a built-in ramp test-pattern source.

## Interface
Parameters:
- `LANES`, 8: number of ADC data lanes (power of two, 2..16).
- `SAMPLE_W`, 8: bits per lane sample.
- `MAX_CH`, 4: largest channel count supported (power of two, ≤ `LANES`).
- `INV_MASK`, 8'b1111_1011: bit i set means lane i pair is P/N swapped on the board and its data must be inverted.
- `SYNC_STAGES`, 3: flops in each control-input synchroniser (≥ 2).
- `DROP_BEATS`, 1: valid beats suppressed after an applied mode change (0..15).

Ports:
- `clk` in 1: ADC divided clock (`divclk`).
- `rst` in 1: synchronous, active-high reset.
- `in_data` in `LANES*SAMPLE_W`: deserialised word; lane i = bits [i*SAMPLE_W +: SAMPLE_W].
- `in_valid` in 1: `in_data` valid this cycle.
- `ch_mode` in 2: asynchronous (GPIO domain) channel mode; requested channel count N = 2^`ch_mode`, clamped to `MAX_CH`.
- `test_en` in 1: asynchronous; when 1, lane data is replaced by the ramp pattern.
- `out_data` out `LANES*SAMPLE_W`: formatted word.
- `out_valid` out 1: `out_data` valid.
- `mode_chg` out 1: one-cycle pulse when a new mode is applied.
- `active_ch` out 2: log2 of the channel count currently applied.

## Operation
- Synchronisers: `ch_mode` and `test_en` each pass through `SYNC_STAGES` flops. All downstream logic uses only the synchronised values.
- Mode apply: when the clamped synced mode ≠ `active_ch`, then on the next edge:
  - load `active_ch`;
  - pulse `mode_chg`;
  - load the drop counter with `DROP_BEATS`.
- A mode change during an active drop window reloads the counter (restart).
- Stage 1 (convert), on `in_valid`, per lane i:
  - if `INV_MASK[i]` = 1: s = d XOR {1'b0, all-ones};
  - otherwise: s = d XOR {1'b1, zeros}.
  - That is: invert, then flip the MSB.
- Test pattern: if synced `test_en` = 1, stage 1 instead stores lane i = `cnt` + i (mod 2^`SAMPLE_W`).
  - `cnt` is a `SAMPLE_W`-bit register that advances by `LANES` per `in_valid` beat while test is enabled and wraps naturally.
  - `cnt` clears to 0 whenever test is disabled.
  - The pattern bypasses conversion but not reordering.
- Stage 2 (reorder): with N = 2^`active_ch` and G = `LANES`/N, output lane k = s*N + c takes stage-1 lane i = c*G + s, for c < N, s < G.
  - N = 1 gives identity.
  - The mode is sampled once per word, so a word is never mixed between modes.
- Drop window: while the drop counter is > 0, each stage-2 valid beat decrements the counter and is emitted with `out_valid` = 0. `out_data` still updates.
- No backpressure; the stream is continuous.

## Timing
- Latency: `in_valid` at edge t → `out_valid`/`out_data` registered at edge t+2. Stage valids follow `in_valid` exactly, with no bubbles inserted.
- Control latency: an async input change is seen at the synchroniser output after `SYNC_STAGES` edges. `active_ch`/`mode_chg` update on the following edge.
- The first word reordered with the new mode is the one entering stage 2 on the edge after `active_ch` updates. With `DROP_BEATS` ≥ 1, that word is suppressed.
- Reset (any edge with `rst` = 1, including mid-stream), all cleared to 0: `out_data`, `out_valid`, `mode_chg`, `active_ch` (1-channel), synchronisers, `cnt`, drop counter, stage valids. In-flight words are discarded.
- After reset, the synchronised `ch_mode` differs from 0 only once it propagates, which produces a normal mode-apply sequence.
- Simultaneous mode change and `in_valid`: the word in stage 1 uses the mode applied on that same edge when it moves to stage 2.

## Test plan
- Convert: mode 0, `test_en`=0, all lanes 0x80 → `out_data` 0xFFFF_FFFF_FF00_FFFF two cycles later. Lanes 0x00 → 0x7F7F_7F7F_7F80_7F7F.
- Reorder 4ch: `ch_mode`=2, `test_en`=1, first beat (`cnt`=0) → 0x0705_0301_0604_0200. Second beat → each byte +8, i.e. 0x0F0D_0B09_0E0C_0A08.
- Reorder 2ch and clamp: `ch_mode`=1 → 0x0703_0602_0501_0400. `ch_mode`=3 → `active_ch`=2, same output as 4ch.
- Mode change mid-stream, continuous `in_valid`: `mode_chg` pulses once `SYNC_STAGES`+1 edges after the change. Exactly `DROP_BEATS` beats have `out_valid`=0. No output word mixes modes. A second change inside the window restarts the drop count.
- Ramp wrap: test enabled for 33 beats → `cnt` wraps 0xF8→0x00 with no gap. Deasserting `test_en` resets `cnt` to 0 and returns converted data.
- Reset mid-stream: assert `rst` 1 cycle during traffic → `out_valid` 0 on the next edge, `active_ch`=0, no stale word emitted afterwards.

Source files
------------

// File: rtl/adc_lane_formatter.sv
// adc_lane_formatter: offset-binary to two's complement lane conversion, channel reorder,
// synchronised mode control with post-change beat drop, and ramp test pattern.
module adc_lane_formatter #(
    parameter int LANES = 8,
    parameter int SAMPLE_W = 8,
    parameter int MAX_CH = 4,
    parameter logic [LANES-1:0] INV_MASK = 8'b1111_1011,
    parameter int SYNC_STAGES = 3,
    parameter int DROP_BEATS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*SAMPLE_W-1:0] in_data,
    input  logic                      in_valid,
    input  logic [1:0]                ch_mode,
    input  logic                      test_en,
    output logic [LANES*SAMPLE_W-1:0] out_data,
    output logic                      out_valid,
    output logic                      mode_chg,
    output logic [1:0]                active_ch
);
    localparam int LOG_L = $clog2(LANES);
    localparam logic [1:0] MAX_LOG = 2'($clog2(MAX_CH));
    localparam int DW = LANES * SAMPLE_W;

    logic [2*SYNC_STAGES-1:0] mode_sync;
    logic [SYNC_STAGES-1:0] test_sync;
    logic [1:0] mode_s, mode_req;
    logic test_s, apply;
    logic [SAMPLE_W-1:0] cnt;
    logic [3:0] drop_cnt;
    logic [DW-1:0] s1_data, conv, reo;
    logic s1_valid;

    assign mode_s = mode_sync[2*SYNC_STAGES-1 -: 2];
    assign test_s = test_sync[SYNC_STAGES-1];
    assign mode_req = mode_s > MAX_LOG ? MAX_LOG : mode_s;
    assign apply = mode_req != active_ch;

    // Swapped pairs arrive inverted, so they need only the low bits flipped.
    always_comb begin
        conv = '0;
        for (int i = 0; i < LANES; i++)
            conv[i*SAMPLE_W +: SAMPLE_W] = test_s ? cnt + SAMPLE_W'(i)
                : in_data[i*SAMPLE_W +: SAMPLE_W] ^ (INV_MASK[i] ? {1'b0, {(SAMPLE_W-1){1'b1}}}
                                                                : {1'b1, {(SAMPLE_W-1){1'b0}}});
    end

    // Output lane k = s*N + c takes input lane c*G + s.
    always_comb begin
        int a, src;
        reo = '0;
        a = int'(active_ch);
        for (int k = 0; k < LANES; k++) begin
            src = ((k & ((1 << a) - 1)) << (LOG_L - a)) | (k >> a);
            reo[k*SAMPLE_W +: SAMPLE_W] = s1_data[src*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sync <= '0;
            test_sync <= '0;
            active_ch <= '0;
            mode_chg  <= 1'b0;
            drop_cnt  <= '0;
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            mode_sync <= {mode_sync[2*SYNC_STAGES-3:0], ch_mode};
            test_sync <= {test_sync[SYNC_STAGES-2:0], test_en};
            active_ch <= mode_req;
            mode_chg  <= apply;
            drop_cnt  <= apply ? 4'(DROP_BEATS) : drop_cnt - 4'(s1_valid && drop_cnt != 4'd0);
            cnt       <= !test_s ? '0 : in_valid ? cnt + SAMPLE_W'(LANES) : cnt;
            s1_valid  <= in_valid;
            if (in_valid) s1_data <= conv;
            out_valid <= s1_valid && drop_cnt == 4'd0;
            if (s1_valid) out_data <= reo;
        end
    end
endmodule
